// File: rtl/md_sched_if.sv
// Handshake/status bundle between the pipeline, the MD issue controller and the MDU.
// Signal names match the controller's original port list.
interface md_sched_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       D_MDOp;
    logic [3:0]       E_MDOp;
    logic             E_Valid;
    logic             MDU_Busy;
    logic             MDU_Start;
    logic [3:0]       MDU_Op;
    logic             Busy;
    logic             Stall_D;
    logic             Err;
    logic [CNT_W-1:0] BusyCycles;
    logic [CNT_W-1:0] StallCycles;

    modport master (
        output D_MDOp, E_MDOp, E_Valid, MDU_Busy,
        input  MDU_Start, MDU_Op, Busy, Stall_D, Err, BusyCycles, StallCycles
    );

    modport slave (
        input  D_MDOp, E_MDOp, E_Valid, MDU_Busy,
        output MDU_Start, MDU_Op, Busy, Stall_D, Err, BusyCycles, StallCycles
    );
endinterface

// File: rtl/md_sched.sv
// MDU issue/hazard controller: issues E-stage MD ops, mirrors MDU occupancy with a
// countdown, stalls D on MD hazards, and keeps sticky error and saturating perf counters.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 32
) (
    input logic        clk,
    input logic        reset,
    md_sched_if.slave  bus
);
    localparam int CNT_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             first_q;
    logic [CNT_W-1:0] busy_cnt_q, stall_cnt_q;

    logic             is_calc, is_move, busy, start, stall;
    logic [3:0]       op;

    assign is_calc = bus.E_Valid && (bus.E_MDOp <= 4'd3);
    assign is_move = bus.E_Valid && (bus.E_MDOp >= 4'd4) && (bus.E_MDOp <= 4'd7);
    assign busy    = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        start   = 1'b0;
        op      = 4'hF;
        case (state_q)
            IDLE: begin
                if (is_calc || is_move) op = bus.E_MDOp;
                if (is_calc) begin
                    start   = 1'b1;
                    state_d = RUN;
                    cnt_d   = (bus.E_MDOp <= 4'd1) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                end
            end
            RUN: begin
                // Any MD op reaching E here means the pipeline failed to stall; drop it.
                if (is_calc || is_move) err_d = 1'b1;
                if (cnt_q > CW'(1)) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The MDU flag lags reset by one cycle, so the first post-reset cycle is not compared.
        if (!first_q && (bus.MDU_Busy != busy)) err_d = 1'b1;
    end

    assign stall = (bus.D_MDOp != 4'hF) && (start || busy);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            first_q     <= 1'b1;
            busy_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            first_q <= 1'b0;
            if (busy && (busy_cnt_q != '1))   busy_cnt_q  <= busy_cnt_q + CNT_W'(1);
            if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.MDU_Start   = start;
    assign bus.MDU_Op      = op;
    assign bus.Busy        = busy;
    assign bus.Stall_D     = stall;
    assign bus.Err         = err_q;
    assign bus.BusyCycles  = busy_cnt_q;
    assign bus.StallCycles = stall_cnt_q;
endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched with a simple latency model of the MDU.
module tb_md_sched;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   m_mult_lat;
    int   m_div_lat;
    int   m_cnt;

    md_sched_if #(.CNT_W(32)) bus ();

    md_sched #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (32)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MDU model: busy for the configured latency after each accepted start.
    always @(posedge clk) begin
        if (rst)                 m_cnt <= 0;
        else if (bus.MDU_Start)  m_cnt <= (bus.MDU_Op <= 4'd1) ? m_mult_lat : m_div_lat;
        else if (m_cnt != 0)     m_cnt <= m_cnt - 1;
    end
    assign bus.MDU_Busy = (m_cnt != 0);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, leave time to settle before checks.
    task automatic cyc(input logic r, input logic [3:0] d, input logic v, input logic [3:0] e);
        @(posedge clk);
        #1;
        rst         = r;
        bus.D_MDOp  = d;
        bus.E_Valid = v;
        bus.E_MDOp  = e;
        #2;
    endtask

    task automatic idle();
        cyc(1'b0, 4'hF, 1'b0, 4'hF);
    endtask

    task automatic do_reset();
        cyc(1'b1, 4'hF, 1'b0, 4'hF);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        m_mult_lat  = 5;
        m_div_lat   = 10;
        rst         = 1'b1;
        bus.D_MDOp  = 4'hF;
        bus.E_Valid = 1'b0;
        bus.E_MDOp  = 4'hF;
        do_reset();
        do_reset();

        // MULT issue and 5-cycle occupancy
        cyc(1'b0, 4'hF, 1'b1, 4'd0);
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_err", 32'(bus.Err), 32'd0);
        chk("rst_bcnt", bus.BusyCycles, 32'd0);
        chk("mult_start", 32'(bus.MDU_Start), 32'd1);
        chk("mult_op", 32'(bus.MDU_Op), 32'd0);
        for (int c = 1; c <= 5; c++) begin
            idle();
            chk($sformatf("mult_busy_c%0d", c), 32'(bus.Busy), 32'd1);
        end
        idle();
        chk("mult_busy_c6", 32'(bus.Busy), 32'd0);
        chk("mult_bcnt", bus.BusyCycles, 32'd5);
        chk("mult_err", 32'(bus.Err), 32'd0);

        // DIVU with MFLO waiting in D
        do_reset();
        cyc(1'b0, 4'd5, 1'b1, 4'd3);
        chk("divu_start", 32'(bus.MDU_Start), 32'd1);
        chk("divu_op", 32'(bus.MDU_Op), 32'd3);
        chk("divu_stall_c0", 32'(bus.Stall_D), 32'd1);
        for (int c = 1; c <= 10; c++) begin
            cyc(1'b0, 4'd5, 1'b0, 4'hF);
            chk($sformatf("divu_stall_c%0d", c), 32'(bus.Stall_D), 32'd1);
        end
        chk("divu_busy_c10", 32'(bus.Busy), 32'd1);
        cyc(1'b0, 4'd5, 1'b0, 4'hF);
        chk("divu_stall_c11", 32'(bus.Stall_D), 32'd0);
        chk("divu_scnt", bus.StallCycles, 32'd11);
        chk("divu_bcnt", bus.BusyCycles, 32'd10);
        chk("divu_err", 32'(bus.Err), 32'd0);

        // Moves, bubbles and non-MD instructions in D
        do_reset();
        cyc(1'b0, 4'hF, 1'b1, 4'd6);
        chk("mthi_op", 32'(bus.MDU_Op), 32'd6);
        chk("mthi_start", 32'(bus.MDU_Start), 32'd0);
        idle();
        chk("mthi_busy", 32'(bus.Busy), 32'd0);
        cyc(1'b0, 4'hF, 1'b0, 4'd0);
        chk("bubble_op", 32'(bus.MDU_Op), 32'hF);
        chk("bubble_start", 32'(bus.MDU_Start), 32'd0);
        cyc(1'b0, 4'hF, 1'b1, 4'd1);
        chk("multu_nomd_stall", 32'(bus.Stall_D), 32'd0);
        idle();
        chk("nomd_busy", 32'(bus.Busy), 32'd1);
        chk("nomd_stall", 32'(bus.Stall_D), 32'd0);

        // DIV forced into E while a MULT runs
        do_reset();
        cyc(1'b0, 4'hF, 1'b1, 4'd0);
        idle();
        idle();
        cyc(1'b0, 4'hF, 1'b1, 4'd2);
        chk("coll_start", 32'(bus.MDU_Start), 32'd0);
        chk("coll_op", 32'(bus.MDU_Op), 32'hF);
        chk("coll_err_c3", 32'(bus.Err), 32'd0);
        idle();
        chk("coll_err_c4", 32'(bus.Err), 32'd1);
        idle();
        chk("coll_busy_c5", 32'(bus.Busy), 32'd1);
        idle();
        chk("coll_busy_c6", 32'(bus.Busy), 32'd0);
        idle();
        chk("coll_err_c7", 32'(bus.Err), 32'd1);

        // MDU whose multiply finishes one cycle early
        m_mult_lat = 4;
        do_reset();
        cyc(1'b0, 4'hF, 1'b1, 4'd0);
        for (int c = 1; c <= 5; c++) begin
            idle();
            chk($sformatf("lat_err_c%0d", c), 32'(bus.Err), 32'd0);
        end
        idle();
        chk("lat_err_c6", 32'(bus.Err), 32'd1);
        m_mult_lat = 5;

        // Reset in the middle of a DIV, then an immediate MULT
        do_reset();
        cyc(1'b0, 4'd4, 1'b1, 4'd2);
        for (int c = 1; c <= 3; c++) cyc(1'b0, 4'd4, 1'b0, 4'hF);
        chk("rdiv_scnt_c3", bus.StallCycles, 32'd3);
        cyc(1'b1, 4'hF, 1'b0, 4'hF);
        cyc(1'b0, 4'hF, 1'b1, 4'd0);
        chk("rdiv_busy", 32'(bus.Busy), 32'd0);
        chk("rdiv_err", 32'(bus.Err), 32'd0);
        chk("rdiv_bcnt", bus.BusyCycles, 32'd0);
        chk("rdiv_scnt", bus.StallCycles, 32'd0);
        chk("rdiv_start", 32'(bus.MDU_Start), 32'd1);
        for (int c = 1; c <= 5; c++) begin
            idle();
            chk($sformatf("rmul_busy_c%0d", c), 32'(bus.Busy), 32'd1);
        end
        idle();
        chk("rmul_busy_c6", 32'(bus.Busy), 32'd0);
        chk("rmul_bcnt", bus.BusyCycles, 32'd5);
        chk("rmul_err", 32'(bus.Err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
